// File: rtl/wr_control.sv
// Write-side sequencer for the systolic array output memory: produces the skewed
// per-lane write-enable staircase and per-lane write addresses for each result block.
module wr_control #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    output logic [WIDTH_HEIGHT-1:0]        wr_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH_HEIGHT-1:0] FIRST_LANE = {{(WIDTH_HEIGHT-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_HEIGHT-1:0] LAST_LANE  = {1'b1, {(WIDTH_HEIGHT-1){1'b0}}};
    localparam logic [WIDTH_HEIGHT-1:0] NO_LANE    = {WIDTH_HEIGHT{1'b0}};

    state_t                  state_q;
    logic [WIDTH_HEIGHT-1:0] wr_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_W-1:0]       addr_q [WIDTH_HEIGHT];
    logic [ADDR_W-1:0]       addr_d [WIDTH_HEIGHT];
    logic                    seq_end_s;

    // Last drain step: only the top lane is still writing.
    assign seq_end_s = (state_q == DRAIN) && (wr_en_q == LAST_LANE);

    // Staircase FSM: grows one lane per cycle in FILL, retires one lane per cycle in DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_en_q <= NO_LANE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (active) begin
                        state_q <= FILL;
                        wr_en_q <= FIRST_LANE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        wr_en_q <= NO_LANE;
                        busy_q  <= 1'b0;
                    end
                end
                FILL: begin
                    busy_q <= 1'b1;
                    if (&wr_en_q) begin
                        state_q <= DRAIN;
                        wr_en_q <= {wr_en_q[WIDTH_HEIGHT-2:0], 1'b0};
                    end else begin
                        state_q <= FILL;
                        wr_en_q <= {wr_en_q[WIDTH_HEIGHT-2:0], 1'b1};
                    end
                end
                DRAIN: begin
                    if (seq_end_s) begin
                        state_q <= IDLE;
                        wr_en_q <= NO_LANE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DRAIN;
                        wr_en_q <= {wr_en_q[WIDTH_HEIGHT-2:0], 1'b0};
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= NO_LANE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane address advance; completion clears every lane, including the top lane's last step.
    always_comb begin
        for (int i = 0; i < WIDTH_HEIGHT; i++) begin
            addr_d[i] = addr_q[i];
        end
        if (seq_end_s) begin
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                addr_d[i] = {ADDR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                if (wr_en_q[i]) begin
                    addr_d[i] = addr_q[i] + ADDR_W'(1);
                end else begin
                    addr_d[i] = addr_q[i];
                end
            end
        end
    end

    // Address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH_HEIGHT; g++) begin : g_addr_pack
            assign wr_addr[ADDR_W*g +: ADDR_W] = addr_q[g];
        end
    endgenerate

    assign wr_en = wr_en_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_wr_control.sv
// Self-checking bench for wr_control: W=4 and W=16 instances share stimulus and are
// checked every cycle against a cycle-position model, plus literal staircase tables.
module tb_wr_control;

    localparam int AW = 8;

    logic          clk;
    logic          reset;
    logic          active;
    logic [3:0]    wr_en4;
    logic [4*AW-1:0]  wr_addr4;
    logic          busy4;
    logic          done4;
    logic [15:0]   wr_en16;
    logic [16*AW-1:0] wr_addr16;
    logic          busy16;
    logic          done16;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int c4       = 0;   // model: cycle position within a sequence, 0 = idle
    int c16      = 0;

    wr_control #(.WIDTH_HEIGHT(4), .ADDR_W(AW)) dut4 (
        .clk(clk), .reset(reset), .active(active),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .busy(busy4), .done(done4)
    );

    wr_control #(.WIDTH_HEIGHT(16), .ADDR_W(AW)) dut16 (
        .clk(clk), .reset(reset), .active(active),
        .wr_en(wr_en16), .wr_addr(wr_addr16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_pos(int c, int w, logic act_in);
        if (c == 0 || c == 2*w) return act_in ? 1 : 0;
        return c + 1;
    endfunction

    function automatic logic [15:0] m_wr_en(int c, int w);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < w; i++) begin
            r[i] = (c >= i + 1) && (c <= i + w);
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] m_addr(int c, int w, int i);
        int n;
        if (c == 0 || c == 2*w) return '0;
        n = c - 1 - i;
        if (n < 0) n = 0;
        if (n > w) n = w;
        return AW'(n);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            c4  <= 0;
            c16 <= 0;
        end else begin
            c4  <= next_pos(c4, 4, active);
            c16 <= next_pos(c16, 16, active);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("w4_wr_en", wr_en4, m_wr_en(c4, 4));
            chk("w4_busy", busy4, (c4 >= 1 && c4 <= 7));
            chk("w4_done", done4, (c4 == 8));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("w4_addr%0d", i), wr_addr4[AW*i +: AW], m_addr(c4, 4, i));
            end
            chk("w16_wr_en", wr_en16, m_wr_en(c16, 16));
            chk("w16_busy", busy16, (c16 >= 1 && c16 <= 31));
            chk("w16_done", done16, (c16 == 32));
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("w16_addr%0d", i), wr_addr16[AW*i +: AW], m_addr(c16, 16, i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0]    tbl_en4   [1:8];
    logic [AW-1:0] tbl_lane0 [1:8];
    logic [AW-1:0] tbl_lane3 [1:8];

    initial begin
        tbl_en4   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        tbl_lane0 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd0};
        tbl_lane3 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        for (int n = 4; n <= 7; n++) tbl_lane3[n] = AW'(n - 4);

        reset  = 1'b1;
        active = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_wr_en4", wr_en4, 4'b0000);
        chk("rst_addr16", wr_addr16, {(16*AW){1'b0}});
        chk("rst_busy_done", {busy4, done4, busy16, done16}, 4'b0000);

        reset  = 1'b0;
        active = 1'b0;
        tick();
        chk("idle_after_rst", {busy4, wr_en4}, 5'b0);

        // Single pulse: literal staircase for W=4 and key points for W=16.
        active = 1'b1;
        tick();
        active = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            if (n <= 8) begin
                chk($sformatf("lit_en4_c%0d", n), wr_en4, tbl_en4[n]);
                chk($sformatf("lit_l0_c%0d", n), wr_addr4[0 +: AW], tbl_lane0[n]);
                chk($sformatf("lit_l3_c%0d", n), wr_addr4[AW*3 +: AW], tbl_lane3[n]);
                chk($sformatf("lit_busy4_c%0d", n), busy4, (n <= 7));
                chk($sformatf("lit_done4_c%0d", n), done4, (n == 8));
            end
            if (n == 16) chk("lit_en16_c16", wr_en16, 16'hFFFF);
            if (n == 31) chk("lit_en16_c31", wr_en16, 16'h8000);
            if (n == 32) chk("lit_end16_c32", {done16, wr_en16}, 17'h10000);
            if (n >= 16 && n <= 31) chk($sformatf("lit_l15_c%0d", n), wr_addr16[AW*15 +: AW], AW'(n - 16));
            tick();
        end
        repeat (3) tick();

        // Active held high: no restart mid-run, back-to-back after done.
        active = 1'b1;
        tick();
        repeat (7) tick();
        chk("b2b_done4", done4, 1'b1);
        tick();
        chk("b2b_restart4", {done4, wr_en4}, 5'b0_0001);
        repeat (40) tick();
        active = 1'b0;
        repeat (40) tick();

        // Reset in cycle 5 of a W=4 run, then a clean run.
        active = 1'b1;
        tick();
        active = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("midrst_outs4", {done4, busy4, wr_en4, wr_addr4}, 38'b0);
        reset  = 1'b0;
        active = 1'b1;
        tick();
        active = 1'b0;
        repeat (40) tick();

        // Randomized starts with occasional resets.
        repeat (3000) begin
            active = ($urandom_range(3) == 0);
            reset  = ($urandom_range(99) == 0);
            tick();
        end
        reset  = 1'b0;
        active = 1'b0;
        repeat (40) tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wr_control.md
Name: wr_control

Overview:
- Write-side sequencer for the systolic array output memory.
- On a start pulse it generates the skewed (diagonal) per-lane write-enable staircase and per-lane write addresses, so that the staggered result rows leaving the array land in consecutive addresses of each output bank.
- Signals completion to the top-level controller.
- Mirrors the read-side staircase, in the write direction.

Parameters:
- WIDTH_HEIGHT, 16, array dimension = number of memory lanes/banks (legal range >= 2)
- ADDR_W, 8, per-lane address width; requires 2^ADDR_W >= WIDTH_HEIGHT

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset, synchronous, active-high
- active  input  1  start request; sampled only in IDLE
- wr_en  output  WIDTH_HEIGHT  per-lane write enable; bit i drives bank i
- wr_addr  output  WIDTH_HEIGHT*ADDR_W  packed per-lane addresses; lane i at bits [ADDR_W*i+ADDR_W-1 : ADDR_W*i]
- busy  output  1  high while in FILL or DRAIN
- done  output  1  one-cycle pulse when a sequence completes

Behaviour:
- All outputs are registered. State machine: IDLE, FILL, DRAIN.
- Reset (synchronous, highest priority over everything including active):
  - state=IDLE, wr_en=0, wr_addr=0 (all lanes), busy=0, done=0.
  - Reset mid-sequence aborts immediately; no done pulse is produced.
- IDLE:
  - wr_en=0, busy=0, every lane address holds 0.
  - active=1 at edge k: at k+1 state=FILL, wr_en=...0001, busy=1.
  - Latency from start is 1 cycle.
- FILL:
  - Each edge: wr_en <= {wr_en[W-2:0], 1'b1}.
  - If current wr_en is all ones: instead wr_en <= {wr_en[W-2:0], 1'b0} and state <= DRAIN.
  - The all-ones pattern is present for exactly one cycle.
- DRAIN:
  - Each edge: wr_en <= {wr_en[W-2:0], 1'b0}.
  - If current wr_en == 1 << (W-1): wr_en <= 0, state <= IDLE, all addresses <= 0, done <= 1, busy <= 0.
- Enable timing (start cycle numbered 1 = first cycle wr_en != 0):
  - wr_en is nonzero for cycles 1 .. 2W-1.
  - Lane i is high for exactly W consecutive cycles, i+1 .. i+W.
  - At cycle 2W: wr_en=0 and done=1.
- Address rules:
  - Lane i address increments by 1 (mod 2^ADDR_W) on each edge where wr_en[i]=1; otherwise it holds.
  - Lane i therefore presents addresses 0,1,...,W-1 on its enabled cycles.
  - The final increment of lane W-1 is overridden by the clear to 0 at completion.
  - Every lane reads 0 in IDLE.
- done:
  - High only in the first IDLE cycle after DRAIN; 0 at all other times.
  - active=1 in that same cycle is accepted: new FILL begins next cycle with wr_en=...0001, done returns to 0.
- active while busy=1 is ignored and not queued.
- No back-pressure: once started, the sequence runs to completion unless reset.

Test Plan:
- Reset state: hold reset 3 cycles with active=1 -> wr_en=0000, all wr_addr=0, busy=0, done=0. The first cycle after release with active=0 stays idle.
- Full sequence, W=4, one-cycle active pulse:
  - wr_en over cycles 1..7 = 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - Cycle 8: wr_en=0000, done=1.
  - busy=1 in cycles 1..7 only.
- Addresses, W=4: lane 0 addr = 0, 1, 2, 3 in cycles 1..4, then holds 4 until clear. Lane 3 addr = 0, 1, 2, 3 in cycles 4..7. All lanes = 0 at cycle 8.
- Default W=16: single pulse -> wr_en=0xFFFF at cycle 16, 0x8000 at cycle 31, 0x0000 with done=1 at cycle 32. Lane 15 presents 0..15 in cycles 16..31.
- Ignored and back-to-back starts:
  - active held high throughout -> no restart mid-sequence.
  - Second sequence begins the cycle after done (wr_en=0001 while done has dropped).
  - Pattern is identical to the first run.
- Reset mid-operation: assert reset at cycle 5 of a W=4 run -> next cycle all outputs 0, no done pulse. A subsequent active pulse produces the full nominal sequence.
